// File: rtl/data_mem_responder.sv
// CPU data-memory responder: byte-addressed RAM plus a 16-byte MMIO window
// holding a TX byte FIFO, STATUS register and a free-running 64-bit cycle counter.
module data_mem_responder #(
   parameter int              XLEN      = 32,
   parameter int              RAM_BYTES = 4096,
   parameter logic [XLEN-1:0] MMIO_BASE = 32'h1000_0000,
   parameter int              TX_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_r,
   input  logic [XLEN/8-1:0] mem_w,
   input  logic [XLEN-1:0]   mem_addr,
   input  logic [XLEN-1:0]   mem_din,
   output logic [XLEN-1:0]   mem_dout,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic              bus_err
);

   localparam int NB = XLEN / 8;
   localparam int AW = $clog2(RAM_BYTES);
   localparam int PW = $clog2(TX_DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]      ram [RAM_BYTES];
   logic [7:0]      fifo [TX_DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count;
   logic            overflow;
   logic            bus_err_q;
   logic [63:0]     cycle_cnt;

   logic [XLEN-1:0] lane_addr [NB];
   logic [NB-1:0]   lane_in_ram;
   logic [XLEN-1:0] win_off;
   logic            in_win, win_aligned, accessed, mmio_acc;
   logic [1:0]      reg_sel;
   logic            err_now;
   logic [XLEN-1:0] ram_rdata, mmio_rdata, status;
   logic            full, pop, push, push_ok, stat_wr;

   // Window offset is computed once; MMIO_BASE is word aligned so the low
   // offset bits give both the alignment check and the register select.
   always_comb begin
      win_off     = mem_addr - MMIO_BASE;
      in_win      = win_off < XLEN'(16);
      win_aligned = win_off[1:0] == 2'b00;
      reg_sel     = win_off[3:2];
      accessed    = mem_r | (|mem_w);
      mmio_acc    = in_win & win_aligned & accessed;
      for (int i = 0; i < NB; i++) begin
         lane_addr[i]   = mem_addr + XLEN'(i);
         lane_in_ram[i] = lane_addr[i] < XLEN'(RAM_BYTES);
      end
      if (in_win)
         err_now = ~win_aligned & accessed;
      else
         err_now = |(~lane_in_ram & ({NB{mem_r}} | mem_w));
   end

   always_comb begin
      ram_rdata = '0;
      for (int i = 0; i < NB; i++)
         if (mem_r && !in_win && lane_in_ram[i])
            ram_rdata[8*i +: 8] = ram[lane_addr[i][AW-1:0]];
   end

   assign full   = count == CW'(TX_DEPTH);
   assign status = {{(XLEN-8){1'b0}}, 4'(count), bus_err_q, overflow, count == '0, full};

   always_comb begin
      mmio_rdata = '0;
      case (reg_sel)
         2'd1:    mmio_rdata = status;
         2'd2:    mmio_rdata = cycle_cnt[31:0];
         2'd3:    mmio_rdata = cycle_cnt[63:32];
         default: mmio_rdata = '0;
      endcase
   end

   always_comb begin
      if (!mem_r)
         mem_dout = '0;
      else if (in_win)
         mem_dout = mmio_acc ? mmio_rdata : '0;
      else
         mem_dout = ram_rdata;
   end

   assign tx_valid = count != '0;
   assign tx_data  = tx_valid ? fifo[rd_ptr] : 8'h00;
   assign bus_err  = bus_err_q;
   assign pop      = tx_valid & tx_ready;
   assign push     = mmio_acc & (reg_sel == 2'd0) & mem_w[0];
   assign stat_wr  = mmio_acc & (reg_sel == 2'd1) & mem_w[0];
   // A push into a full FIFO still lands when the head leaves on the same edge.
   assign push_ok  = push & (~full | pop);

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++)
         if (mem_w[i] && !in_win && lane_in_ram[i])
            ram[lane_addr[i][AW-1:0]] <= mem_din[8*i +: 8];
      if (push_ok)
         fifo[wr_ptr] <= mem_din[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         bus_err_q <= 1'b0;
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if (push_ok)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         count     <= count + CW'(push_ok) - CW'(pop);
         overflow  <= (overflow & ~(stat_wr & mem_din[2])) | (push & full & ~pop);
         // A fresh error wins over a clear in the same cycle.
         bus_err_q <= (bus_err_q & ~(stat_wr & mem_din[3])) | err_now;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM access, MMIO FIFO, errors,
// cycle counter and asynchronous reset.
module tb_data_mem_responder;

   localparam logic [31:0] MB = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_r;
   logic [3:0]  mem_w;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        bus_err;

   int n_vec = 0;
   int n_bad = 0;

   data_mem_responder dut (
      .clk      (clk),
      .reset    (reset),
      .mem_r    (mem_r),
      .mem_w    (mem_w),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .bus_err  (bus_err)
   );

   always #5 clk = ~clk;

   task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      mem_addr = a;
      mem_w    = s;
      mem_din  = d;
      @(posedge clk);
      #1;
      mem_w = 4'b0000;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      mem_r    = 1'b1;
      mem_addr = a;
      #1;
      d     = mem_dout;
      mem_r = 1'b0;
   endtask

   task automatic rd_edge(input logic [31:0] a, output logic [31:0] d);
      mem_r    = 1'b1;
      mem_addr = a;
      #1;
      d = mem_dout;
      @(posedge clk);
      #1;
      mem_r = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      n_vec++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
      n_vec++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
      n_vec++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL reset_bus_err got %b exp 0", bus_err); end
      rd(MB + 4, d);
      n_vec++; if (d !== 32'h0000_0002) begin n_bad++; $display("FAIL reset_status got %h exp 00000002", d); end
   endtask

   task automatic test_store_load();
      logic [31:0] d;
      wr(32'h0, 4'b0001, 32'h0000_0084);
      wr(32'h0, 4'b0010, 32'h0000_E800);
      rd(32'h0, d);
      n_vec++; if (d[15:0] !== 16'hE884) begin n_bad++; $display("FAIL store_load got %h exp e884", d[15:0]); end
      n_vec++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL store_load_err got %b exp 0", bus_err); end
      mem_addr = 32'h0;
      #1;
      n_vec++; if (mem_dout !== 32'h0) begin n_bad++; $display("FAIL idle_dout got %h exp 0", mem_dout); end
   endtask

   task automatic test_unaligned();
      logic [31:0] d;
      wr(32'h2, 4'b1111, 32'hDEAD_BEEF);
      rd(32'h2, d);
      n_vec++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL unaligned_rd got %h exp deadbeef", d); end
      rd(32'h0, d);
      n_vec++; if (d !== 32'hBEEF_E884) begin n_bad++; $display("FAIL aligned_rd got %h exp beefe884", d); end
      wr(32'h8, 4'b1111, 32'hAABB_CCDD);
      mem_r    = 1'b1;
      mem_w    = 4'b1111;
      mem_addr = 32'h8;
      mem_din  = 32'h1122_3344;
      #1;
      n_vec++; if (mem_dout !== 32'hAABB_CCDD) begin n_bad++; $display("FAIL rw_old got %h exp aabbccdd", mem_dout); end
      @(posedge clk);
      #1;
      mem_w = 4'b0000;
      #1;
      n_vec++; if (mem_dout !== 32'h1122_3344) begin n_bad++; $display("FAIL rw_new got %h exp 11223344", mem_dout); end
      mem_r = 1'b0;
   endtask

   task automatic test_fifo_overflow();
      logic [31:0] d;
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) wr(MB, 4'b0001, 32'h41 + i);
      n_vec++; if (tx_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid got %b exp 1", tx_valid); end
      n_vec++; if (tx_data !== 8'h41) begin n_bad++; $display("FAIL ovf_head got %h exp 41", tx_data); end
      rd(MB + 4, d);
      n_vec++; if (d !== 32'h0000_0045) begin n_bad++; $display("FAIL ovf_status got %h exp 00000045", d); end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
            n_bad++; $display("FAIL ovf_drain%0d got v=%b %h exp v=1 %h", i, tx_valid, tx_data, 8'(8'h41 + i));
         end
         @(posedge clk);
         #1;
      end
      tx_ready = 1'b0;
      n_vec++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL drained_valid got %b exp 0", tx_valid); end
      rd(MB + 4, d);
      n_vec++; if (d !== 32'h0000_0006) begin n_bad++; $display("FAIL drained_status got %h exp 00000006", d); end
      wr(MB + 4, 4'b0001, 32'h4);
      rd(MB + 4, d);
      n_vec++; if (d !== 32'h0000_0002) begin n_bad++; $display("FAIL ovf_clear got %h exp 00000002", d); end
   endtask

   task automatic test_push_pop_full();
      logic [31:0] d;
      logic [7:0]  exp_b [4] = '{8'h42, 8'h43, 8'h44, 8'h55};
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) wr(MB, 4'b0001, 32'h41 + i);
      mem_addr = MB;
      mem_din  = 32'h55;
      mem_w    = 4'b0001;
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      mem_w    = 4'b0000;
      tx_ready = 1'b0;
      rd(MB + 4, d);
      n_vec++; if (d !== 32'h0000_0041) begin n_bad++; $display("FAIL fullpp_status got %h exp 00000041", d); end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
            n_bad++; $display("FAIL fullpp_drain%0d got v=%b %h exp v=1 %h", i, tx_valid, tx_data, exp_b[i]);
         end
         @(posedge clk);
         #1;
      end
      tx_ready = 1'b0;
      n_vec++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL fullpp_empty got %b exp 0", tx_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      wr(MB, 4'b0001, 32'hAA);
      wr(MB, 4'b0001, 32'hBB);
      tx_ready = 1'b1;
      wr(MB, 4'b0001, 32'hCC);
      tx_ready = 1'b0;
      rd(MB + 4, d);
      n_vec++; if (d !== 32'h0000_0020) begin n_bad++; $display("FAIL b2b_status got %h exp 00000020", d); end
      n_vec++; if (tx_data !== 8'hBB) begin n_bad++; $display("FAIL b2b_head got %h exp bb", tx_data); end
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      n_vec++; if (tx_data !== 8'hCC) begin n_bad++; $display("FAIL b2b_next got %h exp cc", tx_data); end
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      n_vec++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got %b exp 0", tx_valid); end
   endtask

   task automatic test_errors();
      logic [31:0] d, c0, c1;
      rd_edge(MB + 2, d);
      n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL unaligned_mmio got %h exp 0", d); end
      rd_edge(32'h0000_1000, d);
      n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL beyond_ram got %h exp 0", d); end
      n_vec++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b exp 1", bus_err); end
      wr(MB + 4, 4'b0001, 32'h8);
      n_vec++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b exp 0", bus_err); end
      wr(32'd4094, 4'b0011, 32'h0000_A5C3);
      n_vec++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL edge_wr_err got %b exp 0", bus_err); end
      rd_edge(32'd4094, d);
      n_vec++; if (d !== 32'h0000_A5C3) begin n_bad++; $display("FAIL edge_rd got %h exp 0000a5c3", d); end
      n_vec++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL edge_rd_err got %b exp 1", bus_err); end
      wr(MB + 4, 4'b0001, 32'h8);
      wr(32'd4094, 4'b0100, 32'h00FF_0000);
      n_vec++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL oob_strobe_err got %b exp 1", bus_err); end
      wr(MB + 4, 4'b0001, 32'h8);
      wr(MB + 8, 4'b1111, 32'h0);
      n_vec++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL cycle_wr_err got %b exp 0", bus_err); end
      rd(MB + 8, c0);
      repeat (5) @(posedge clk);
      #1;
      rd(MB + 8, c1);
      n_vec++; if (c1 - c0 !== 32'd5) begin n_bad++; $display("FAIL cycle_delta got %0d exp 5", c1 - c0); end
      rd(MB + 12, d);
      n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL cycle_hi got %h exp 0", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      bit          found = 1'b0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) wr(MB, 4'b0001, 32'h01 + i);
      rd_edge(32'h0000_2000, d);
      for (int i = 0; i < 1000 && !found; i++) begin
         rd(MB + 8, d);
         if (d == 32'd100) found = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      n_vec++; if (!found) begin n_bad++; $display("FAIL cnt_reach100 got %0d exp 100", d); end
      n_vec++; if (tx_valid !== 1'b1 || bus_err !== 1'b1) begin n_bad++; $display("FAIL pre_reset got v=%b e=%b exp 1 1", tx_valid, bus_err); end
      #2;
      reset = 1'b1;
      #1;
      n_vec++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL async_valid got %b exp 0", tx_valid); end
      n_vec++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL async_err got %b exp 0", bus_err); end
      rd(MB + 8, d);
      n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL async_cnt got %0d exp 0", d); end
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rd(MB + 8, d);
      n_vec++; if (d !== 32'd3) begin n_bad++; $display("FAIL cnt_restart got %0d exp 3", d); end
      rd(32'h0, d);
      n_vec++; if (d !== 32'hBEEF_E884) begin n_bad++; $display("FAIL ram_kept got %h exp beefe884", d); end
   endtask

   initial begin
      reset    = 1'b1;
      mem_r    = 1'b0;
      mem_w    = 4'b0000;
      mem_addr = 32'h0;
      mem_din  = 32'h0;
      tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_store_load();
      test_unaligned();
      test_fifo_overflow();
      test_push_pop_full();
      test_back_to_back();
      test_errors();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory port; the CPU is the initiator.
- Accepts the CPU's single-cycle read and byte-strobed write requests.
- Serves them from an internal byte-addressed RAM plus a small MMIO region.
- MMIO region: TX byte FIFO with a valid/ready drain port, a free-running cycle counter and a sticky status/error register.

Parameters:
XLEN, 32, data/address width; 32 only (MMIO map assumes 4-byte words)
RAM_BYTES, 4096, RAM size in bytes; power of 2; RAM occupies addresses 0..RAM_BYTES-1
MMIO_BASE, 32'h1000_0000, base of the 16-byte MMIO window
TX_DEPTH, 4, TX FIFO entries; power of 2, >=2

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
mem_r  in  1  read request, same-cycle response
mem_w  in  XLEN/8  write byte strobes; bit i writes byte lane i at mem_addr+i
mem_addr  in  XLEN  byte address of lane 0
mem_din  in  XLEN  write data, lane i = bits [8i+7:8i]
mem_dout  out  XLEN  read data, combinational
tx_valid  out  1  TX FIFO head valid
tx_data  out  8  TX FIFO head byte
tx_ready  in  1  consumer accepts head
bus_err  out  1  sticky access-error flag

Behaviour:
- Reset (async, high): FIFO empty (tx_valid=0, tx_data=0), cycle counter=0, overflow=0, bus_err=0.
- RAM contents are not reset.
- mem_dout is combinational and never X on a defined address.
- Reads:
  - mem_r=1: lane i = byte at mem_addr+i; little-endian; zero wait states; reads pre-edge state.
  - mem_r=0: mem_dout=0.
- RAM decode:
  - Byte k is in RAM iff k < RAM_BYTES.
  - Lanes decode independently; unaligned accesses inside RAM are legal.
  - A lane falling outside both RAM and MMIO reads 0, ignores its write, and sets bus_err if that lane was read or strobed.
- Writes:
  - Each strobed lane is written on the rising edge.
  - mem_r and mem_w may both be asserted: mem_dout shows old data in that cycle, new data from the next cycle.
- MMIO decode: accessed only when mem_addr is in MMIO_BASE..MMIO_BASE+15 and word-aligned. Any MMIO address not word-aligned: no effect, read 0, bus_err set.
- MMIO registers:
  - +0x0 TX_DATA
    - Write with mem_w[0]=1 pushes mem_din[7:0].
    - Read returns 0.
  - +0x4 STATUS, read:
    - bit0 = full, bit1 = empty, bit2 = overflow, bit3 = bus_err.
    - bits[7:4] = FIFO count; other bits 0.
    - Write with mem_w[0]=1: bit2=1 clears overflow, bit3=1 clears bus_err.
  - +0x8 CYCLE_LO, +0xC CYCLE_HI
    - Read-only 64-bit counter; increments every cycle and wraps at 2^64-1 to 0.
    - Reads are combinational, current value.
    - Writes ignored, no error.
- TX FIFO:
  - tx_valid = count != 0; tx_data = head byte.
  - Pop on edge when tx_valid && tx_ready.
  - Push when full:
    - With a pop in the same edge: push accepted, count unchanged.
    - Without a pop: byte dropped, overflow set.
  - Push and pop on the same edge when non-empty and non-full: count unchanged, order preserved.
  - Read/write pointers wrap modulo TX_DEPTH.
- Error flag precedence: a STATUS write clearing bus_err in the same cycle as a new error leaves bus_err=1.
- bus_err is also driven directly as an output.

Test Plan:
- Basic store/load:
  - Stimulus: write mem_w=4'b0001, addr 0, din 32'h84, then next cycle mem_w=4'b0010, addr 0, din 32'h0000_E800; then read addr 0.
  - Required: mem_dout[15:0]=16'hE884, bus_err=0.
- Unaligned word:
  - Stimulus: write 32'hDEADBEEF strobes 4'b1111 at addr 2; then read addr 2, then read addr 0.
  - Required: first read 32'hDEADBEEF; second read has bytes [31:16]=16'hBEEF.
- FIFO fill/overflow:
  - Stimulus: tx_ready=0; push 8'h41..8'h45 (5 pushes, TX_DEPTH=4).
  - Required: tx_valid=1, tx_data=8'h41, STATUS=32'h0000_0045 (count 4, overflow, full).
  - Then tx_ready=1 for 4 cycles: bytes 41,42,43,44 appear in order, then tx_valid=0, STATUS bit1=1.
- Push on full with pop:
  - Stimulus: FIFO full with 41..44, tx_ready=1, push 8'h55 in the same cycle.
  - Required: count stays 4, overflow stays 0, drain order 42,43,44,55.
- Errors and counter:
  - Stimulus: read MMIO_BASE+2, then read RAM_BYTES.
  - Required: both return 0, bus_err=1.
  - Stimulus: STATUS write with din bit3=1.
  - Required: bus_err=0.
  - Stimulus: read CYCLE_LO twice, 5 cycles apart.
  - Required: difference is 5.
- Reset mid-operation:
  - Stimulus: FIFO holds 3 bytes, bus_err=1, counter=100; pulse reset mid-cycle.
  - Required: tx_valid, bus_err and counter drop immediately without a clock edge; after release CYCLE_LO counts up from 0.
  - RAM bytes written before reset still read back.
